sprite_mover: RTL and testbench

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover.sv | 158 +++++++++++++++
 tb/tb_sprite_mover.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// Moves a SIZE x SIZE square one pixel per step tick in a latched button direction,
// clamping or wrapping at the screen edge and refusing steps into a fixed obstacle.
module sprite_mover #(
  parameter int SCREEN_W    = 96,
  parameter int SCREEN_H    = 64,
  parameter int SIZE        = 9,
  parameter int START_X     = 0,
  parameter int START_Y     = 54,
  parameter int STEP_DIV    = 833333,
  parameter int OBS_X0      = 65,
  parameter int OBS_X1      = 95,
  parameter int OBS_Y0      = 0,
  parameter int OBS_Y1      = 29,
  parameter int WRAP        = 0,
  parameter int STOP_ON_HIT = 0,
  localparam int XW = $clog2(SCREEN_W),
  localparam int YW = $clog2(SCREEN_H)
) (
  input  logic          clock_25Mhz,
  input  logic          reset_n,
  input  logic          switch,
  input  logic [3:0]    pb,
  output logic [XW-1:0] current_x,
  output logic [YW-1:0] current_y,
  output logic [3:0]    dir,
  output logic          step_tick,
  output logic          blocked
);

  localparam int SXW = XW + 2;
  localparam int SYW = YW + 2;
  localparam int CW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(STEP_DIV - 1);
  localparam logic [XW-1:0] HOME_X    = XW'(START_X);
  localparam logic [YW-1:0] HOME_Y    = YW'(START_Y);

  localparam logic signed [SXW-1:0] X_ONE  = 1;
  localparam logic signed [SXW-1:0] X_MAX  = SXW'(SCREEN_W - SIZE);
  localparam logic signed [SXW-1:0] X_SIZE = SXW'(SIZE);
  localparam logic signed [SXW-1:0] OX0    = SXW'(OBS_X0);
  localparam logic signed [SXW-1:0] OX1    = SXW'(OBS_X1);
  localparam logic signed [SYW-1:0] Y_ONE  = 1;
  localparam logic signed [SYW-1:0] Y_MAX  = SYW'(SCREEN_H - SIZE);
  localparam logic signed [SYW-1:0] Y_SIZE = SYW'(SIZE);
  localparam logic signed [SYW-1:0] OY0    = SYW'(OBS_Y0);
  localparam logic signed [SYW-1:0] OY1    = SYW'(OBS_Y1);

  // The home square must be a legal place to sit, otherwise switch=0 parks it illegally.
  if (START_X < 0 || START_Y < 0 ||
      START_X + SIZE > SCREEN_W || START_Y + SIZE > SCREEN_H ||
      (START_X <= OBS_X1 && START_X + SIZE - 1 >= OBS_X0 &&
       START_Y <= OBS_Y1 && START_Y + SIZE - 1 >= OBS_Y0) ||
      STEP_DIV < 1) begin : g_bad_config
    $error("sprite_mover: home square is off-screen or overlaps the obstacle, or STEP_DIV < 1");
  end

  logic [3:0]    pb_meta;
  logic [3:0]    pbs;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    dir_pick;

  logic signed [SXW-1:0] x_s, nx, nx_w;
  logic signed [SYW-1:0] y_s, ny, ny_w;
  logic                  out_of_bounds;
  logic                  hit_obstacle;
  logic                  reject;
  logic                  move;

  always_ff @(posedge clock_25Mhz or negedge reset_n) begin
    if (!reset_n) begin
      pb_meta <= '0;
      pbs     <= '0;
    end else begin
      pb_meta <= pb;
      pbs     <= pb_meta;
    end
  end

  always_ff @(posedge clock_25Mhz or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!switch) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign step_tick = switch && (tick_cnt == TICK_LAST);

  always_comb begin
    dir_pick = 4'b0000;
    if      (pbs[0]) dir_pick = 4'b0001;
    else if (pbs[1]) dir_pick = 4'b0010;
    else if (pbs[2]) dir_pick = 4'b0100;
    else if (pbs[3]) dir_pick = 4'b1000;
  end

  // Candidate position; the two guard bits keep 0-1 negative instead of aliasing.
  always_comb begin
    x_s = $signed({2'b00, current_x});
    y_s = $signed({2'b00, current_y});
    nx  = x_s;
    ny  = y_s;
    if (dir[0]) ny = y_s - Y_ONE;
    if (dir[1]) ny = y_s + Y_ONE;
    if (dir[2]) nx = x_s - X_ONE;
    if (dir[3]) nx = x_s + X_ONE;

    nx_w          = nx;
    ny_w          = ny;
    out_of_bounds = 1'b0;
    if (WRAP != 0) begin
      if (nx[SXW-1])      nx_w = X_MAX;
      else if (nx > X_MAX) nx_w = '0;
      if (ny[SYW-1])      ny_w = Y_MAX;
      else if (ny > Y_MAX) ny_w = '0;
    end else begin
      out_of_bounds = nx[SXW-1] || (nx > X_MAX) || ny[SYW-1] || (ny > Y_MAX);
    end

    hit_obstacle = (nx_w <= OX1) && (nx_w + X_SIZE - X_ONE >= OX0) &&
                   (ny_w <= OY1) && (ny_w + Y_SIZE - Y_ONE >= OY0);
    reject       = out_of_bounds || hit_obstacle;
    move         = step_tick && (dir != 4'b0000);
    blocked      = move && reject;
  end

  always_ff @(posedge clock_25Mhz or negedge reset_n) begin
    if (!reset_n) begin
      current_x <= HOME_X;
      current_y <= HOME_Y;
    end else if (!switch) begin
      current_x <= HOME_X;
      current_y <= HOME_Y;
    end else if (move && !reject) begin
      current_x <= nx_w[XW-1:0];
      current_y <= ny_w[YW-1:0];
    end
  end

  // The step in the tick cycle already used the old dir; a rejection may clear it.
  always_ff @(posedge clock_25Mhz or negedge reset_n) begin
    if (!reset_n) begin
      dir <= 4'b0000;
    end else if (!switch) begin
      dir <= 4'b0000;
    end else if (blocked && (STOP_ON_HIT != 0)) begin
      dir <= 4'b0000;
    end else if (pbs != 4'b0000) begin
      dir <= dir_pick;
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: clamp and wrap instances share stimulus; a screen-level
// reference model queues the expected state at every step tick for the monitor.
module tb_sprite_mover;

  localparam int SW = 96, SH = 64, SZ = 9, SX = 0, SY = 54, DIV = 4;
  localparam int OX0 = 65, OX1 = 95, OY0 = 0, OY1 = 29, STOP = 0;
  localparam int EW = 1 + 7 + 6 + 4;

  // clock / reset block
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic switch = 1'b0;
  logic [3:0] pb = 4'b0000;
  always #5 clk = ~clk;

  logic [6:0] x_c, x_w;
  logic [5:0] y_c, y_w;
  logic [3:0] dir_c, dir_w;
  logic       tick_c, tick_w, blk_c, blk_w;

  sprite_mover #(.STEP_DIV(DIV), .WRAP(0)) dut_c (
    .clock_25Mhz(clk), .reset_n(reset_n), .switch(switch), .pb(pb),
    .current_x(x_c), .current_y(y_c), .dir(dir_c), .step_tick(tick_c), .blocked(blk_c)
  );

  sprite_mover #(.STEP_DIV(DIV), .WRAP(1)) dut_w (
    .clock_25Mhz(clk), .reset_n(reset_n), .switch(switch), .pb(pb),
    .current_x(x_w), .current_y(y_w), .dir(dir_w), .step_tick(tick_w), .blocked(blk_w)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q_c[$];
  logic [EW-1:0] exp_q_w[$];

  // reference model: state as it stands after the most recent clock edge
  int         m_x[2], m_y[2], m_cnt;
  logic [3:0] m_dir[2];
  logic [3:0] h1, h2;

  always @(negedge clk) begin
    logic [3:0] pbs_m;
    bit         tick, ok;
    int         nx, ny;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_x[i] = SX; m_y[i] = SY; m_dir[i] = 4'b0000;
      end
      m_cnt = 0; h1 = 4'b0000; h2 = 4'b0000;
    end else begin
      pbs_m = h2; h2 = h1; h1 = pb;
      if (!switch) begin
        for (int i = 0; i < 2; i++) begin
          m_x[i] = SX; m_y[i] = SY; m_dir[i] = 4'b0000;
        end
        m_cnt = 0;
      end else begin
        tick = (m_cnt == DIV - 1);
        for (int i = 0; i < 2; i++) begin
          ok = 1'b1;
          if (tick) begin
            if (m_dir[i] != 4'b0000) begin
              nx = m_x[i]; ny = m_y[i];
              if (m_dir[i] == 4'b0001) ny = ny - 1;
              if (m_dir[i] == 4'b0010) ny = ny + 1;
              if (m_dir[i] == 4'b0100) nx = nx - 1;
              if (m_dir[i] == 4'b1000) nx = nx + 1;
              if (i == 1) begin
                if (nx < 0) nx = SW - SZ; else if (nx > SW - SZ) nx = 0;
                if (ny < 0) ny = SH - SZ; else if (ny > SH - SZ) ny = 0;
              end else if (nx < 0 || ny < 0 || nx + SZ > SW || ny + SZ > SH) begin
                ok = 1'b0;
              end
              if (nx <= OX1 && nx + SZ - 1 >= OX0 && ny <= OY1 && ny + SZ - 1 >= OY0) ok = 1'b0;
            end
            if (i == 0) exp_q_c.push_back({!ok, 7'(m_x[i]), 6'(m_y[i]), m_dir[i]});
            else        exp_q_w.push_back({!ok, 7'(m_x[i]), 6'(m_y[i]), m_dir[i]});
            if (m_dir[i] != 4'b0000 && ok) begin
              m_x[i] = nx; m_y[i] = ny;
            end
          end
          if (!ok && STOP != 0) m_dir[i] = 4'b0000;
          else if (pbs_m[0]) m_dir[i] = 4'b0001;
          else if (pbs_m[1]) m_dir[i] = 4'b0010;
          else if (pbs_m[2]) m_dir[i] = 4'b0100;
          else if (pbs_m[3]) m_dir[i] = 4'b1000;
        end
        m_cnt = tick ? 0 : m_cnt + 1;
      end
    end
  end

  // scoreboard monitor
  task automatic mon(input int i, input logic tk, input logic bk, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    int sz;
    sz = (i == 0) ? exp_q_c.size() : exp_q_w.size();
    n_checks++;
    if (tk) begin
      if (sz == 0) begin
        n_errors++;
        $display("FAIL step_%0d: step_tick=1 but no step expected", i);
      end else begin
        e = (i == 0) ? exp_q_c.pop_front() : exp_q_w.pop_front();
        if (got !== e) begin
          n_errors++;
          $display("FAIL step_%0d: got blk=%0b x=%0d y=%0d dir=%b, expected blk=%0b x=%0d y=%0d dir=%b",
                   i, got[17], got[16:10], got[9:4], got[3:0], e[17], e[16:10], e[9:4], e[3:0]);
        end
      end
    end else if (sz != 0 || bk) begin
      n_errors++;
      $display("FAIL idle_%0d: step_tick=0 blocked=%0b, expected step_tick=%0b blocked=0", i, bk, sz != 0);
      if (i == 0) exp_q_c.delete(); else exp_q_w.delete();
    end
  endtask

  always @(negedge clk) begin
    #1;
    mon(0, tick_c, blk_c, {blk_c, x_c, y_c, dir_c});
    mon(1, tick_w, blk_w, {blk_w, x_w, y_w, dir_w});
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic pulse_pb(input logic [3:0] v);
    pb = v;
    cyc(1);
    pb = 4'b0000;
  endtask

  initial begin
    int n, n2;
    cyc(2);
    check("reset_x", x_c, SX);
    check("reset_y", y_c, SY);
    check("reset_dir", dir_c, 0);
    check("reset_tick", tick_c, 0);
    check("reset_blk", blk_c, 0);
    check("reset_x_wrap", x_w, SX);

    // three-cycle button latency, then steps four cycles apart
    reset_n = 1'b1;
    cyc(1);
    switch = 1'b1;
    cyc(2);
    pulse_pb(4'b1000);
    cyc(1);
    check("dir_before_latency", dir_c, 0);
    cyc(1);
    check("dir_after_latency", dir_c, 4'b1000);
    n = 0;
    while (x_c != 1 && n < 20) begin cyc(1); n++; end
    if (n >= 20) timeout("first_step");
    check("x_first_step", x_c, 1);
    n2 = 0;
    while (x_c == 1 && n2 < 20) begin cyc(1); n2++; end
    check("step_spacing", n2, DIV);
    check("x_second_step", x_c, 2);

    // run right until the square column touches the obstacle, then go up
    n = 0;
    while (m_x[0] < 57 && n < 400) begin cyc(1); n++; end
    if (n >= 400) timeout("reach_x57");
    pulse_pb(4'b0001);
    cyc(160);
    n = 0;
    while (!tick_c && n < 10) begin cyc(1); n++; end
    check("obstacle_blocked", blk_c, 1);
    check("obstacle_y", y_c, 30);
    check("obstacle_y_wrap", y_w, 30);

    // switch low parks at home; re-enable restarts the tick phase
    switch = 1'b0;
    cyc(1);
    check("park_x", x_c, SX);
    check("park_y", y_c, SY);
    check("park_dir", dir_c, 0);
    check("park_dir_wrap", dir_w, 0);
    switch = 1'b1;
    cyc(1);
    check("reenable_tick1", tick_c, 0);
    cyc(1);
    check("reenable_tick2", tick_c, 0);
    check("reenable_x", x_c, SX);
    cyc(1);
    check("reenable_tick3", tick_c, 1);
    cyc(1);
    check("reenable_y", y_c, SY);

    // left from home: clamp refuses, wrap jumps to the right edge
    pulse_pb(4'b0100);
    n = 0;
    while (x_w == 0 && n < 30) begin cyc(1); n++; end
    if (n >= 30) timeout("wrap_left");
    check("wrap_left_x", x_w, SW - SZ);
    check("clamp_left_x", x_c, 0);

    // priority among simultaneous buttons
    pulse_pb(4'b0111);
    cyc(2);
    check("priority_dir", dir_c, 4'b0001);
    check("priority_dir_wrap", dir_w, 4'b0001);

    // randomized traffic
    repeat (300) begin
      n = $urandom_range(0, 9);
      if (n < 4) begin
        pb = 4'($urandom_range(1, 15));
        cyc($urandom_range(1, 3));
        pb = 4'b0000;
      end else if (n == 4) begin
        switch = 1'b0;
        cyc($urandom_range(1, 5));
        switch = 1'b1;
      end
      cyc($urandom_range(1, 12));
    end

    // asynchronous reset away from home
    switch = 1'b0;
    cyc(1);
    switch = 1'b1;
    pulse_pb(4'b1000);
    n = 0;
    while (m_x[0] < 5 && n < 100) begin cyc(1); n++; end
    if (n >= 100) timeout("reach_x5");
    pulse_pb(4'b0001);
    n = 0;
    while (m_y[0] > 50 && n < 100) begin cyc(1); n++; end
    if (n >= 100) timeout("reach_y50");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_x", x_c, SX);
    check("async_reset_y", y_c, SY);
    check("async_reset_dir", dir_c, 0);
    check("async_reset_x_wrap", x_w, SX);
    check("async_reset_tick", tick_c, 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(6);
    check("after_reset_x", x_c, SX);
    check("after_reset_y", y_c, SY);

    cyc(2);
    check("queue_c_drained", exp_q_c.size(), 0);
    check("queue_w_drained", exp_q_w.size(), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
